// File: rtl/dcache_refill_ctrl_pkg.sv
// dcache_refill_ctrl_pkg: shared types and line geometry for the dcache miss handler.
//   state_t     controller FSM states
//   miss_req_t  request fields latched at acceptance
//   cache_tag_t tag entry layout {tag[19:0], v, d}
package dcache_refill_ctrl_pkg;

    localparam int WAY_NUM        = 2;
    localparam int WORDS_PER_LINE = 4;
    localparam int TAG_W          = 22;
    localparam int IDX_LOW        = 4;

    typedef enum logic [3:0] {
        IDLE, WB_RD, WB_REQ, WB_DATA, WB_RESP, RF_REQ, RF_DATA, RF_TAG, DONE
    } state_t;

    typedef struct packed {
        logic [31-IDX_LOW:0] line;
        logic [1:0]          word;
        logic [WAY_NUM-1:0]  way;
        logic [31-IDX_LOW:0] victim_line;
        logic [3:0]          strb;
        logic [31:0]         wdata;
    } miss_req_t;

    typedef struct packed {
        logic [19:0] tag;
        logic        v;
        logic        d;
    } cache_tag_t;

    function automatic logic [31:0] merge_store(input logic [31:0] beat, input logic [31:0] wdata,
                                                input logic [3:0] strb);
        return {strb[3] ? wdata[31:24] : beat[31:24],
                strb[2] ? wdata[23:16] : beat[23:16],
                strb[1] ? wdata[15:8]  : beat[15:8],
                strb[0] ? wdata[7:0]   : beat[7:0]};
    endfunction

    function automatic cache_tag_t make_tag(input logic [19:0] tag, input logic d);
        return '{tag: tag, v: 1'b1, d: d};
    endfunction

endpackage

// File: rtl/dcache_refill_ctrl_line_buf.sv
// line_buf: one cache line of 32-bit words with a write port and an indexed read port.
//   clk, rst_n     clock, async active-low reset (clears contents)
//   we/waddr/wdata word write
//   raddr/rdata    combinational word read
module line_buf
    import dcache_refill_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [1:0]  raddr,
    output logic [31:0] rdata
);
    logic [WORDS_PER_LINE-1:0][31:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: commit-side miss handler; writes back a dirty victim, refills the line, installs it.
//   miss_*        commit miss request (valid/ready), completion via done_valid/done_rdata
//   c_*           dcache port-1 tag/data write and read (c_rdata one-cycle latency)
//   rd_*          burst read bus (request handshake, beats never stalled)
//   wr_*          burst write bus (request, beat handshake, response)
module dcache_refill_ctrl
    import dcache_refill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               miss_valid,
    output logic               miss_ready,
    input  logic [31:0]        miss_paddr,
    input  logic [WAY_NUM-1:0] miss_way,
    input  logic               miss_dirty,
    input  logic [31:0]        miss_victim_addr,
    input  logic [3:0]         miss_strb,
    input  logic [31:0]        miss_wdata,
    output logic               done_valid,
    output logic [31:0]        done_rdata,
    output logic [31:0]        c_addr,
    output logic [WAY_NUM-1:0] c_way,
    output logic               c_tag_we,
    output logic [TAG_W-1:0]   c_tag_data,
    output logic [3:0]         c_strb,
    output logic [31:0]        c_wdata,
    input  logic [31:0]        c_rdata,
    output logic               rd_req_valid,
    input  logic               rd_req_ready,
    output logic [31:0]        rd_addr,
    input  logic               rd_valid,
    input  logic [31:0]        rd_data,
    input  logic               rd_last,
    output logic               wr_req_valid,
    input  logic               wr_req_ready,
    output logic [31:0]        wr_addr,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [31:0]        wr_data,
    output logic               wr_last,
    input  logic               wr_resp_valid
);
    state_t     state;
    miss_req_t  req;
    logic [2:0] cnt;
    logic       wb_we;
    logic [1:0] wb_waddr;
    logic       unused_bits;

    // Offsets of both addresses are irrelevant: everything works on whole lines.
    assign unused_bits = ^{miss_paddr[IDX_LOW-3:0], miss_victim_addr[IDX_LOW-1:0]};

    // Reads issued at cnt=k return one cycle later, so word k lands while cnt=k+1.
    assign wb_we    = state == WB_RD && cnt != 3'd0;
    assign wb_waddr = cnt[1:0] - 2'd1;

    line_buf u_wb_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_we),
        .waddr (wb_waddr),
        .wdata (c_rdata),
        .raddr (cnt[1:0]),
        .rdata (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req        <= '0;
            cnt        <= '0;
            done_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (miss_valid) begin
                    req   <= '{line: miss_paddr[31:IDX_LOW], word: miss_paddr[3:2], way: miss_way,
                               victim_line: miss_victim_addr[31:IDX_LOW], strb: miss_strb,
                               wdata: miss_wdata};
                    cnt   <= '0;
                    state <= miss_dirty ? WB_RD : RF_REQ;
                end
                WB_RD: begin
                    cnt   <= cnt == 3'd4 ? 3'd0 : cnt + 3'd1;
                    state <= cnt == 3'd4 ? WB_REQ : WB_RD;
                end
                WB_REQ: if (wr_req_ready) state <= WB_DATA;
                WB_DATA: if (wr_ready) begin
                    cnt   <= cnt == 3'd3 ? 3'd0 : cnt + 3'd1;
                    state <= cnt == 3'd3 ? WB_RESP : WB_DATA;
                end
                WB_RESP: if (wr_resp_valid) state <= RF_REQ;
                RF_REQ: if (rd_req_ready) state <= RF_DATA;
                RF_DATA: if (rd_valid) begin
                    if (cnt[1:0] == req.word)
                        done_rdata <= rd_data;
                    // A missing or early rd_last still ends the burst after four beats.
                    cnt   <= (rd_last || cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
                    state <= (rd_last || cnt == 3'd3) ? RF_TAG : RF_DATA;
                end
                RF_TAG: state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        c_addr     = '0;
        c_way      = '0;
        c_tag_we   = 1'b0;
        c_tag_data = '0;
        c_strb     = '0;
        c_wdata    = '0;
        case (state)
            WB_RD: if (cnt != 3'd4) begin
                c_addr = {req.victim_line, cnt[1:0], 2'b00};
                c_way  = req.way;
            end
            RF_DATA: if (rd_valid) begin
                c_addr  = {req.line, cnt[1:0], 2'b00};
                c_way   = req.way;
                c_strb  = 4'hf;
                c_wdata = cnt[1:0] == req.word ? merge_store(rd_data, req.wdata, req.strb) : rd_data;
            end
            RF_TAG: begin
                c_addr     = {req.line, 4'b0000};
                c_way      = req.way;
                c_tag_we   = 1'b1;
                c_tag_data = make_tag(req.line[31-IDX_LOW:12-IDX_LOW], |req.strb);
            end
            default: ;
        endcase
    end

    assign miss_ready   = state == IDLE;
    assign done_valid   = state == DONE;
    assign wr_req_valid = state == WB_REQ;
    assign wr_addr      = {req.victim_line, 4'b0000};
    assign wr_valid     = state == WB_DATA;
    assign wr_last      = state == WB_DATA && cnt == 3'd3;
    assign rd_req_valid = state == RF_REQ;
    assign rd_addr      = {req.line, 4'b0000};
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// tb_dcache_refill_ctrl: directed self-checking bench for dcache_refill_ctrl.
module tb_dcache_refill_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_valid, miss_ready, miss_dirty;
    logic [31:0] miss_paddr, miss_victim_addr, miss_wdata;
    logic [1:0]  miss_way;
    logic [3:0]  miss_strb;
    logic        done_valid;
    logic [31:0] done_rdata;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [1:0]  c_way;
    logic        c_tag_we;
    logic [21:0] c_tag_data;
    logic [3:0]  c_strb;
    logic        rd_req_valid, rd_req_ready, rd_valid, rd_last;
    logic [31:0] rd_addr, rd_data;
    logic        wr_req_valid, wr_req_ready, wr_valid, wr_ready, wr_last, wr_resp_valid;
    logic [31:0] wr_addr, wr_data;
    int          passed = 0;
    int          total = 0;

    dcache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_paddr(miss_paddr),
        .miss_way(miss_way), .miss_dirty(miss_dirty), .miss_victim_addr(miss_victim_addr),
        .miss_strb(miss_strb), .miss_wdata(miss_wdata),
        .done_valid(done_valid), .done_rdata(done_rdata),
        .c_addr(c_addr), .c_way(c_way), .c_tag_we(c_tag_we), .c_tag_data(c_tag_data),
        .c_strb(c_strb), .c_wdata(c_wdata), .c_rdata(c_rdata),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_addr(wr_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .wr_resp_valid(wr_resp_valid)
    );

    always #5 clk = ~clk;

    // Port-1 read model: word k of the addressed line reads back as 0xB0+k one cycle later.
    always @(posedge clk) c_rdata <= 32'hB0 + {30'd0, c_addr[3:2]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives four zero-wait read beats and checks the matching port-1 writes.
    task automatic refill_beats(input logic [31:0] base, input logic [1:0] way,
                                input logic [3:0][31:0] beat, input logic [3:0][31:0] exp_w);
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1;
            rd_data  = beat[i];
            rd_last  = i == 3;
            #1;
            chk($sformatf("beat%0d_addr", i), c_addr, base + 32'(4 * i));
            chk($sformatf("beat%0d_way", i), {30'd0, c_way}, {30'd0, way});
            chk($sformatf("beat%0d_strb", i), {28'd0, c_strb}, 32'hf);
            chk($sformatf("beat%0d_wdata", i), c_wdata, exp_w[i]);
            chk($sformatf("beat%0d_miss_ready", i), {31'd0, miss_ready}, 32'd0);
            step();
        end
        rd_valid = 1'b0;
        rd_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {miss_valid, miss_dirty, miss_strb, miss_way} = '0;
        {miss_paddr, miss_victim_addr, miss_wdata, rd_data} = '0;
        {rd_req_ready, rd_valid, rd_last, wr_req_ready, wr_ready, wr_resp_valid} = '0;
        #12;
        chk("rst_miss_ready", {31'd0, miss_ready}, 32'd1);
        chk("rst_valids", {28'd0, done_valid, rd_req_valid, wr_req_valid, wr_valid}, 32'd0);
        chk("rst_port1", {25'd0, c_tag_we, c_strb, c_way}, 32'd0);
        rst_n = 1'b1;
        step();

        // Clean load miss, zero-wait bus
        miss_valid = 1'b1; miss_paddr = 32'h1000_0024; miss_way = 2'b01;
        rd_req_ready = 1'b1;
        #1;
        chk("t1_ready_idle", {31'd0, miss_ready}, 32'd1);
        step();
        miss_valid = 1'b0;
        chk("t1_rd_req_valid", {31'd0, rd_req_valid}, 32'd1);
        chk("t1_rd_addr", rd_addr, 32'h1000_0020);
        chk("t1_c_way_idle", {30'd0, c_way}, 32'd0);
        step();
        refill_beats(32'h1000_0020, 2'b01, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                     {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("t1_tag_we", {31'd0, c_tag_we}, 32'd1);
        chk("t1_tag_data", {10'd0, c_tag_data}, 32'h0004_0002);
        chk("t1_not_done_yet", {31'd0, done_valid}, 32'd0);
        step();
        chk("t1_done_valid", {31'd0, done_valid}, 32'd1);
        chk("t1_done_rdata", done_rdata, 32'hA1);
        chk("t1_tag_we_off", {31'd0, c_tag_we}, 32'd0);
        step();
        chk("t1_done_pulse", {31'd0, done_valid}, 32'd0);
        chk("t1_ready_back", {31'd0, miss_ready}, 32'd1);

        // Store miss with byte merge into word 2
        miss_valid = 1'b1; miss_paddr = 32'h1000_0048; miss_way = 2'b10;
        miss_strb = 4'b0011; miss_wdata = 32'hDEAD_BEEF;
        step();
        miss_valid = 1'b0; miss_strb = 4'b0;
        step();
        refill_beats(32'h1000_0040, 2'b10, {32'h0000_0103, 32'h1122_3344, 32'h0000_0101, 32'h0000_0100},
                     {32'h0000_0103, 32'h1122_BEEF, 32'h0000_0101, 32'h0000_0100});
        chk("t2_tag_data_dirty", {10'd0, c_tag_data}, 32'h0004_0003);
        step();
        chk("t2_done_rdata", done_rdata, 32'h1122_3344);
        step();

        // Dirty victim write-back with request/beat backpressure
        miss_valid = 1'b1; miss_paddr = 32'h3000_0014; miss_way = 2'b01; miss_dirty = 1'b1;
        miss_victim_addr = 32'h2000_0030; rd_req_ready = 1'b0;
        step();
        miss_valid = 1'b0; miss_dirty = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wb_rd%0d_addr", k), c_addr, 32'h2000_0030 + 32'(4 * k));
            chk($sformatf("wb_rd%0d_port", k), {25'd0, c_tag_we, c_strb, c_way}, 32'd1);
            step();
        end
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wb_req_hold%0d", k), {31'd0, wr_req_valid}, 32'd1);
            chk($sformatf("wb_addr_hold%0d", k), wr_addr, 32'h2000_0030);
            step();
        end
        wr_req_ready = 1'b1;
        step();
        wr_req_ready = 1'b0;
        chk("wb_req_dropped", {31'd0, wr_req_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wb_beat_hold%0d", k), {wr_valid, wr_last, wr_data[29:0]}, {2'b10, 30'hB0});
            step();
        end
        wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wb_beat%0d", k), {wr_valid, wr_last, wr_data[29:0]},
                {1'b1, k == 3, 30'hB0 + 30'(k)});
            step();
        end
        wr_ready = 1'b0;
        chk("wb_resp_wait_wr", {31'd0, wr_valid}, 32'd0);
        rd_req_ready = 1'b1;
        step();
        chk("wb_no_rd_before_resp", {31'd0, rd_req_valid}, 32'd0);
        wr_resp_valid = 1'b1;
        step();
        wr_resp_valid = 1'b0;
        chk("wb_rd_after_resp", {31'd0, rd_req_valid}, 32'd1);
        chk("wb_rd_addr", rd_addr, 32'h3000_0010);
        step();
        refill_beats(32'h3000_0010, 2'b01, {32'hC3, 32'hC2, 32'hC1, 32'hC0},
                     {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        chk("wb_tag_data", {10'd0, c_tag_data}, 32'h000C_0002);
        step();
        chk("wb_done_rdata", done_rdata, 32'hC1);
        step();

        // Async reset in the middle of the refill burst
        miss_valid = 1'b1; miss_paddr = 32'h1000_0000; miss_way = 2'b01;
        step();
        miss_valid = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            rd_valid = 1'b1; rd_data = 32'hE0 + 32'(i);
            step();
        end
        rd_data = 32'hE2;
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_port1", {25'd0, c_tag_we, c_strb, c_way}, 32'd0);
        chk("ar_ready", {31'd0, miss_ready}, 32'd1);
        chk("ar_valids", {31'd0, rd_req_valid | done_valid}, 32'd0);
        rd_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("ar_ready_after", {31'd0, miss_ready}, 32'd1);

        // Back-to-back misses with miss_valid held high
        miss_valid = 1'b1; miss_paddr = 32'h1000_0040; miss_way = 2'b10;
        step();
        chk("bb_busy_rf_req", {31'd0, miss_ready}, 32'd0);
        step();
        refill_beats(32'h1000_0040, 2'b10, {32'hD3, 32'hD2, 32'hD1, 32'hD0},
                     {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        chk("bb_busy_tag", {31'd0, miss_ready}, 32'd0);
        step();
        chk("bb_busy_done", {done_valid, miss_ready}, 2'b10);
        step();
        chk("bb_ready_after_done", {done_valid, miss_ready}, 2'b01);
        step();
        miss_valid = 1'b0;
        chk("bb_second_accepted", {rd_req_valid, miss_ready}, 2'b10);
        step();
        refill_beats(32'h1000_0040, 2'b10, {32'hF3, 32'hF2, 32'hF1, 32'hF0},
                     {32'hF3, 32'hF2, 32'hF1, 32'hF0});
        step();
        chk("bb_second_done", {done_valid, done_rdata[30:0]}, {1'b1, 31'hF0});
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Commit-side miss handler for the 2-way, 4-word-line, VIPT dcache.
- Accepts one cacheable miss at a time and writes back the victim line if it is dirty.
- Refills the line over a simple burst bus and drives the dcache write port (tag/data port 1) to install the line.
- Optionally merges a pending store into the refilled line, then responds to commit.

Parameters:
- WAY_NUM, 2, cache ways (one-hot way select width).
- WORDS_PER_LINE, 4, 32-bit words per line; burst length.
- TAG_W, 22, tag entry width: {tag[19:0], v, d}.
- IDX_LOW, 4, lowest paddr bit of line index (paddr[11:4] selects a set).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- miss_valid  in  1  commit miss request valid
- miss_ready  out  1  controller idle, request accepted when both high
- miss_paddr  in  32  missing address
- miss_way  in  2  one-hot victim way
- miss_dirty  in  1  victim dirty
- miss_victim_addr  in  32  victim line address ({victim tag, index, offset})
- miss_strb  in  4  store byte strobe; 0 means load
- miss_wdata  in  32  store data
- done_valid  out  1  one-cycle completion pulse
- done_rdata  out  32  word at miss_paddr[3:2] after refill, pre-merge
- c_addr  out  32  dcache port-1 address
- c_way  out  2  port-1 way select
- c_tag_we  out  1  tag write enable
- c_tag_data  out  TAG_W  tag write data
- c_strb  out  4  data byte write enables
- c_wdata  out  32  data write data
- c_rdata  in  32  port-1 read data of selected way, one-cycle latency
- rd_req_valid/rd_req_ready  out/in  1  bus read request handshake
- rd_addr  out  32  line-aligned read address
- rd_valid  in  1  read beat valid (bus never stalls on the controller side)
- rd_data  in  32  read beat
- rd_last  in  1  last beat
- wr_req_valid/wr_req_ready  out/in  1  bus write request handshake
- wr_addr  out  32  line-aligned write address
- wr_valid/wr_ready  out/in  1  write beat handshake
- wr_data  out  32  write beat
- wr_last  out  1  last write beat
- wr_resp_valid  in  1  write response

Behaviour:
- Reset (async, rst_n=0): state IDLE, miss_ready=1, all valids 0, c_tag_we=0, c_strb=0, c_way=0, beat counters 0, buffers 0.
- IDLE: miss_ready=1. On miss_valid&miss_ready, latch request; next state WB_RD if miss_dirty, else RF_REQ.
- WB_RD: issue port-1 reads for words 0..3 on consecutive cycles (c_strb=0, c_tag_we=0).
  - Capture c_rdata one cycle later into wb_buf[k].
  - Leaves after 5 cycles to WB_REQ.
- WB_REQ: wr_req_valid=1, wr_addr={victim[31:4],4'b0}; hold until wr_req_ready, then WB_DATA.
- WB_DATA: present wb_buf[cnt]; advance cnt on wr_valid&wr_ready; wr_last when cnt==3. After the last handshake go to WB_RESP.
- WB_RESP: wait wr_resp_valid, then RF_REQ.
- RF_REQ: rd_req_valid=1, rd_addr={paddr[31:4],4'b0}; hold until rd_req_ready, then RF_DATA.
- RF_DATA: each rd_valid beat writes port 1 in the same cycle.
  - c_addr={paddr[31:4],cnt,2'b0}, c_way=latched way, c_strb=4'hf.
  - c_wdata = beat with store bytes merged where cnt==paddr[3:2].
  - done_rdata captured from the unmerged beat at that cnt.
  - On rd_last, go to RF_TAG. rd_last before cnt==3 or cnt overflow is a protocol error; the controller goes to RF_TAG anyway.
- RF_TAG: one cycle c_tag_we=1, c_tag_data={paddr[31:12],1'b1,|strb}; then DONE.
- DONE: done_valid=1 for one cycle, then IDLE. miss_ready is reasserted the cycle after DONE.
- Latency, clean load miss with zero-wait bus: accept → RF_REQ 1 cycle → 4 beats → RF_TAG → DONE, i.e. done_valid 7 cycles after acceptance.
- No abort: flush does not cancel in-flight bus transactions. Commit holds stall until done_valid.
- Victim write-back address uses miss_victim_addr[31:4] only; offsets are ignored.
- The controller never drives port 1 outside WB_RD/RF_DATA/RF_TAG. c_way=0 otherwise, so stale writes are impossible.

Decomposition:
- Shared package: state enum (IDLE, WB_RD, WB_REQ, WB_DATA, WB_RESP, RF_REQ, RF_DATA, RF_TAG, DONE), the miss request struct, cache_tag_t layout, and the line-size constants.
- One natural sub-module: line_buf (4×32 register file with a write port and an indexed read port), used for the write-back buffer.

Test Plan:
- Clean load miss:
  - Stimulus: paddr=0x1000_0024, way=2'b01, dirty=0; bus returns 0xA0..0xA3 with no wait.
  - Response: 4 data writes at 0x1000_0020..2C, way 01; tag_data={0x10000,1,0}; done_rdata=0xA1; done_valid at cycle 7.
- Store miss merge:
  - Stimulus: strb=4'b0011, wdata=0xDEAD_BEEF, paddr offset word 2; beat2=0x1122_3344.
  - Response: c_wdata=0x1122_BEEF on beat 2; tag d=1.
- Dirty victim:
  - Stimulus: miss_dirty=1, victim_addr=0x2000_0030, c_rdata returns 0xB0..0xB3.
  - Response: wr_addr=0x2000_0030; beats B0..B3 with wr_last on the 4th; read request issued only after wr_resp_valid.
- Bus backpressure:
  - Stimulus: wr_req_ready and wr_ready low for 3 cycles each.
  - Response: request and beat held stable; no beat skipped or duplicated.
- Async reset mid-RF_DATA after 2 beats:
  - Response: outputs reset immediately; c_strb=0; miss_ready=1 after release.
- Back-to-back misses:
  - Stimulus: miss_valid held high.
  - Response: second accepted only the cycle after done_valid; miss_ready=0 throughout the first miss.
